// File: rtl/axi_pkg.sv
// Shared types and helpers for the single-beat AXI memory responder.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ISSUE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  // WUSER carries a one-hot size mask; anything that is not one-hot means a full word.
  function automatic logic [3:0] wuser_to_size(input logic [3:0] wuser);
    case (wuser)
      4'b0001: return 4'd1;
      4'b0010: return 4'd2;
      4'b0100: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// Turns the write size mask and byte offset into memory byte enables and lane-aligned data.
module axi_wstrb_gen
  import axi_pkg::*;
(
  input  logic [3:0]  wuser,
  input  logic [2:0]  offset,
  input  logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [63:0] lane_data
);

  logic [7:0] size_mask;

  // Strobes and data shift left by the byte offset; lanes pushed past byte 7 fall off the word.
  always_comb begin
    case (wuser_to_size(wuser))
      4'd1:    size_mask = 8'h01;
      4'd2:    size_mask = 8'h03;
      4'd4:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    wstrb     = size_mask << offset;
    lane_data = wdata << {offset, 3'b000};
  end

endmodule

// File: rtl/axi_mem_slave.sv
// Single-beat AXI responder in front of a single-port synchronous memory.
//
// Read FSM
//   state   | meaning
//   R_IDLE  | ARREADY high, waiting for a read request
//   R_ISSUE | issue memory read (stalls while a write owns the port); DECERR skips memory
//   R_WAIT  | count down the memory read latency, capture mem_rdata
//   R_RESP  | RVALID/RLAST high, data held until RREADY
//
// Write FSM
//   state   | meaning
//   W_IDLE  | AWREADY high, waiting for a write address
//   W_DATA  | WREADY high; memory write issued in the W handshake cycle
//   W_RESP  | BVALID high until BREADY
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 64,
  parameter int                 RD_LATENCY = 1,
  parameter logic [ADDR_W-1:0]  MEM_BASE   = 32'h8000_0000,
  parameter logic [ADDR_W-1:0]  MEM_SIZE   = 32'h0800_0000
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                ARVALID,
  output logic                ARREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [2:0]          ARPROT,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic                RLAST,
  output logic [1:0]          RRESP,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [2:0]          AWPROT,
  input  logic                WVALID,
  output logic                WREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic                WLAST,
  input  logic [3:0]          WUSER,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [1:0]          BRESP,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-4:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [7:0]          mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int              CNT_W    = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LATENCY - 1);

  rd_state_t          rd_state_q, rd_state_d;
  wr_state_t          wr_state_q, wr_state_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;

  logic [ADDR_W-1:0]  ar_off, aw_off;
  logic               ar_in_range, aw_in_range;
  logic               rd_fire, wr_fire;
  logic [7:0]         gen_wstrb;
  logic [63:0]        gen_wdata;
  logic               unused_ok;

  assign ar_off      = araddr_q - MEM_BASE;
  assign aw_off      = awaddr_q - MEM_BASE;
  assign ar_in_range = (araddr_q >= MEM_BASE) && (ar_off < MEM_SIZE);
  assign aw_in_range = (awaddr_q >= MEM_BASE) && (aw_off < MEM_SIZE);
  assign unused_ok   = ^{ARPROT, AWPROT, ar_off[2:0]};

  axi_wstrb_gen u_wstrb_gen (
    .wuser     (WUSER),
    .offset    (aw_off[2:0]),
    .wdata     (WDATA),
    .wstrb     (gen_wstrb),
    .lane_data (gen_wdata)
  );

  // Write channel: address, data beat (memory write happens on the W handshake), response.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    bresp_d    = bresp_q;
    wr_fire    = 1'b0;
    AWREADY    = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) begin
          awaddr_d   = AWADDR;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          if (!aw_in_range) begin
            bresp_d = RESP_DECERR;
          end else if (!WLAST) begin
            bresp_d = RESP_SLVERR;
          end else begin
            bresp_d = RESP_OKAY;
            wr_fire = 1'b1;
          end
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read channel: a write in the same cycle takes the port, so the read issue retries.
  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    lat_cnt_d  = lat_cnt_q;
    rd_fire    = 1'b0;
    ARREADY    = 1'b0;
    RVALID     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) begin
          araddr_d   = ARADDR;
          rd_state_d = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (!ar_in_range) begin
          rdata_d    = '0;
          rresp_d    = RESP_DECERR;
          rd_state_d = R_RESP;
        end else if (!wr_fire) begin
          rd_fire    = 1'b1;
          lat_cnt_d  = LAT_LOAD;
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (lat_cnt_q == '0) begin
          rdata_d    = mem_rdata;
          rresp_d    = RESP_OKAY;
          rd_state_d = R_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      R_RESP: begin
        RVALID = 1'b1;
        if (RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Memory port mux; outputs are zero whenever no access is made.
  always_comb begin
    mem_en    = wr_fire | rd_fire;
    mem_we    = wr_fire;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (wr_fire) begin
      mem_addr  = aw_off[ADDR_W-1:3];
      mem_wdata = gen_wdata;
      mem_wstrb = gen_wstrb;
    end else if (rd_fire) begin
      mem_addr = ar_off[ADDR_W-1:3];
    end
  end

  assign RDATA = rdata_q;
  assign RRESP = rresp_q;
  assign RLAST = RVALID;
  assign BRESP = bresp_q;

  // State registers; reset drops any in-flight transaction.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      araddr_q   <= '0;
      awaddr_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      bresp_q    <= RESP_OKAY;
      lat_cnt_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      araddr_q   <= araddr_d;
      awaddr_q   <= awaddr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      bresp_q    <= bresp_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave with a small behavioural memory on the mem_* port.
module tb_axi_mem_slave;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        ARVALID = 1'b0, ARREADY;
  logic [31:0] ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        RVALID, RREADY = 1'b0, RLAST;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        AWVALID = 1'b0, AWREADY;
  logic [31:0] AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        WVALID = 1'b0, WREADY, WLAST = 1'b0;
  logic [63:0] WDATA = '0;
  logic [3:0]  WUSER = '0;
  logic        BVALID, BREADY = 1'b0;
  logic [1:0]  BRESP;
  logic        mem_en, mem_we;
  logic [28:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mem [16];

  always #5 ACLK = ~ACLK;

  axi_mem_slave #(
    .ADDR_W(32), .DATA_W(64), .RD_LATENCY(1),
    .MEM_BASE(32'h8000_0000), .MEM_SIZE(32'h0800_0000)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST), .WUSER(WUSER),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous memory, one cycle read latency.
  always @(posedge ACLK) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 8; b++)
        if (mem_wstrb[b]) mem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[3:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required done", $time);
    $fatal(1);
  end

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [3:0] u);
    @(negedge ACLK); AWVALID = 1'b1; AWADDR = a;
    @(negedge ACLK); AWVALID = 1'b0; WVALID = 1'b1; WDATA = d; WUSER = u; WLAST = 1'b1;
    @(negedge ACLK); WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    @(negedge ACLK); BREADY = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (ARREADY !== 1'b1) begin n_err++; $display("FAIL rst_arready: got %b want 1", ARREADY); end
    n_cmp++; if (AWREADY !== 1'b1) begin n_err++; $display("FAIL rst_awready: got %b want 1", AWREADY); end
    n_cmp++; if ({RVALID, BVALID, WREADY, RLAST, mem_en, mem_we} !== 6'b0) begin
      n_err++; $display("FAIL rst_ctrl: got %b want 000000", {RVALID, BVALID, WREADY, RLAST, mem_en, mem_we});
    end
    n_cmp++; if ({RDATA, RRESP, BRESP, mem_wstrb} !== 76'b0) begin
      n_err++; $display("FAIL rst_data: got rdata=%h rresp=%b bresp=%b strb=%h want all 0", RDATA, RRESP, BRESP, mem_wstrb);
    end
  endtask

  task automatic test_write_vec(input logic [31:0] a, input logic [63:0] d, input logic [3:0] u,
                                input logic last, input logic een, input logic [7:0] estrb,
                                input logic [63:0] edata, input logic [28:0] eaddr, input logic [1:0] er);
    @(negedge ACLK); AWVALID = 1'b1; AWADDR = a; #1;
    n_cmp++; if (AWREADY !== 1'b1) begin n_err++; $display("FAIL wr_awready @%h: got %b want 1", a, AWREADY); end
    @(negedge ACLK); AWVALID = 1'b0; WVALID = 1'b1; WDATA = d; WUSER = u; WLAST = last; #1;
    n_cmp++; if (WREADY !== 1'b1) begin n_err++; $display("FAIL wr_wready @%h: got %b want 1", a, WREADY); end
    n_cmp++; if (mem_en !== een) begin n_err++; $display("FAIL wr_mem_en @%h: got %b want %b", a, mem_en, een); end
    if (een) begin
      n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL wr_mem_we @%h: got %b want 1", a, mem_we); end
      n_cmp++; if (mem_wstrb !== estrb) begin n_err++; $display("FAIL wr_strb @%h: got %h want %h", a, mem_wstrb, estrb); end
      n_cmp++; if (mem_wdata !== edata) begin n_err++; $display("FAIL wr_wdata @%h: got %h want %h", a, mem_wdata, edata); end
      n_cmp++; if (mem_addr !== eaddr) begin n_err++; $display("FAIL wr_addr @%h: got %h want %h", a, mem_addr, eaddr); end
    end
    @(negedge ACLK); WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1; #1;
    n_cmp++; if (BVALID !== 1'b1) begin n_err++; $display("FAIL wr_bvalid @%h: got %b want 1", a, BVALID); end
    n_cmp++; if (BRESP !== er) begin n_err++; $display("FAIL wr_bresp @%h: got %b want %b", a, BRESP, er); end
    @(negedge ACLK); BREADY = 1'b0; #1;
    n_cmp++; if ({BVALID, AWREADY} !== 2'b01) begin n_err++; $display("FAIL wr_done @%h: got bvalid,awready=%b want 01", a, {BVALID, AWREADY}); end
  endtask

  task automatic test_write();
    do_write(32'h8000_0000, 64'h0, 4'b1000);
    do_write(32'h8000_0020, 64'h0, 4'b1000);
    test_write_vec(32'h8000_0003, 64'hBEEF, 4'b0010, 1'b1, 1'b1, 8'h18, 64'h0000_00BE_EF00_0000, 29'd0, 2'b00);
    test_write_vec(32'h8000_0006, 64'hDDCC_BBAA, 4'b0100, 1'b1, 1'b1, 8'hC0, 64'hBBAA_0000_0000_0000, 29'd0, 2'b00);
    test_write_vec(32'h8000_0008, 64'h0102_0304_0506_0708, 4'b0011, 1'b1, 1'b1, 8'hFF, 64'h0102_0304_0506_0708, 29'd1, 2'b00);
    test_write_vec(32'h8000_0021, 64'hA5, 4'b0001, 1'b1, 1'b1, 8'h02, 64'hA500, 29'd4, 2'b00);
    test_write_vec(32'h87FF_FFF8, 64'hFEED_FACE_00C0_FFEE, 4'b1000, 1'b1, 1'b1, 8'hFF, 64'hFEED_FACE_00C0_FFEE, 29'h00FF_FFFF, 2'b00);
    test_write_vec(32'h9000_0000, 64'h1, 4'b1000, 1'b1, 1'b0, 8'h0, 64'h0, 29'd0, 2'b11);
    test_write_vec(32'h8800_0000, 64'h1, 4'b1000, 1'b1, 1'b0, 8'h0, 64'h0, 29'd0, 2'b11);
    test_write_vec(32'h8000_0000, 64'h1, 4'b1000, 1'b0, 1'b0, 8'h0, 64'h0, 29'd0, 2'b10);
    test_write_vec(32'h7FFF_FFF8, 64'h1, 4'b1000, 1'b0, 1'b0, 8'h0, 64'h0, 29'd0, 2'b11);
  endtask

  task automatic test_read_vec(input logic [31:0] a, input logic [63:0] ed, input logic [1:0] er,
                               input int ecyc, input logic [28:0] eaddr);
    @(negedge ACLK); ARVALID = 1'b1; ARADDR = a; RREADY = 1'b1; #1;
    n_cmp++; if (ARREADY !== 1'b1) begin n_err++; $display("FAIL rd_arready @%h: got %b want 1", a, ARREADY); end
    for (int c = 1; c <= ecyc; c++) begin
      @(negedge ACLK); ARVALID = 1'b0; #1;
      if (c == 1) begin
        n_cmp++; if (mem_en !== (er == 2'b00)) begin n_err++; $display("FAIL rd_mem_en @%h: got %b want %b", a, mem_en, er == 2'b00); end
        if (er == 2'b00) begin
          n_cmp++; if ({mem_we, mem_addr} !== {1'b0, eaddr}) begin n_err++; $display("FAIL rd_issue @%h: got we=%b addr=%h want we=0 addr=%h", a, mem_we, mem_addr, eaddr); end
        end
      end
      if (c < ecyc) begin
        n_cmp++; if (RVALID !== 1'b0) begin n_err++; $display("FAIL rd_early @%h cyc%0d: got rvalid=%b want 0", a, c, RVALID); end
      end else begin
        n_cmp++; if ({RVALID, RLAST} !== 2'b11) begin n_err++; $display("FAIL rd_rvalid @%h cyc%0d: got rvalid,rlast=%b want 11", a, c, {RVALID, RLAST}); end
        n_cmp++; if (RDATA !== ed) begin n_err++; $display("FAIL rd_data @%h: got %h want %h", a, RDATA, ed); end
        n_cmp++; if (RRESP !== er) begin n_err++; $display("FAIL rd_resp @%h: got %b want %b", a, RRESP, er); end
      end
    end
    @(negedge ACLK); RREADY = 1'b0; #1;
    n_cmp++; if ({RVALID, ARREADY} !== 2'b01) begin n_err++; $display("FAIL rd_done @%h: got rvalid,arready=%b want 01", a, {RVALID, ARREADY}); end
  endtask

  task automatic test_read();
    do_write(32'h8000_0010, 64'h1122_3344_5566_7788, 4'b1000);
    test_read_vec(32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00, 3, 29'd2);
    test_read_vec(32'h8000_0015, 64'h1122_3344_5566_7788, 2'b00, 3, 29'd2);
    test_read_vec(32'h8000_0000, 64'hBBAA_00BE_EF00_0000, 2'b00, 3, 29'd0);
    test_read_vec(32'h8000_0008, 64'h0102_0304_0506_0708, 2'b00, 3, 29'd1);
    test_read_vec(32'h8000_0020, 64'h0000_0000_0000_A500, 2'b00, 3, 29'd4);
    test_read_vec(32'h87FF_FFF8, 64'hFEED_FACE_00C0_FFEE, 2'b00, 3, 29'h00FF_FFFF);
    test_read_vec(32'h0000_1000, 64'h0, 2'b11, 2, 29'd0);
    test_read_vec(32'h8800_0000, 64'h0, 2'b11, 2, 29'd0);
    test_read_vec(32'h7FFF_FFFF, 64'h0, 2'b11, 2, 29'd0);
  endtask

  task automatic test_same_word();
    @(negedge ACLK); AWVALID = 1'b1; AWADDR = 32'h8000_0010;
    @(negedge ACLK); AWVALID = 1'b0; WVALID = 1'b1; WDATA = 64'hCAFE_F00D_1234_5678; WUSER = 4'b1000; WLAST = 1'b1;
    ARVALID = 1'b1; ARADDR = 32'h8000_0010; RREADY = 1'b1; #1;
    n_cmp++; if ({ARREADY, mem_en, mem_we} !== 3'b111) begin n_err++; $display("FAIL same_c1: got arready,en,we=%b want 111", {ARREADY, mem_en, mem_we}); end
    @(negedge ACLK); WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0; BREADY = 1'b1; #1;
    n_cmp++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 29'd2}) begin n_err++; $display("FAIL same_rd_issue: got en=%b we=%b addr=%h want 1 0 2", mem_en, mem_we, mem_addr); end
    n_cmp++; if (BVALID !== 1'b1) begin n_err++; $display("FAIL same_bvalid: got %b want 1", BVALID); end
    @(negedge ACLK); BREADY = 1'b0; #1;
    n_cmp++; if (RVALID !== 1'b0) begin n_err++; $display("FAIL same_early: got rvalid=%b want 0", RVALID); end
    @(negedge ACLK); #1;
    n_cmp++; if (RVALID !== 1'b1) begin n_err++; $display("FAIL same_rvalid: got %b want 1", RVALID); end
    n_cmp++; if (RDATA !== 64'hCAFE_F00D_1234_5678) begin n_err++; $display("FAIL same_data: got %h want cafef00d12345678", RDATA); end
    @(negedge ACLK); RREADY = 1'b0; #1;
    n_cmp++; if (RVALID !== 1'b0) begin n_err++; $display("FAIL same_done: got rvalid=%b want 0", RVALID); end
  endtask

  task automatic test_stall();
    @(negedge ACLK); AWVALID = 1'b1; AWADDR = 32'h8000_0010; ARVALID = 1'b1; ARADDR = 32'h8000_0010; RREADY = 1'b1;
    @(negedge ACLK); AWVALID = 1'b0; ARVALID = 1'b0; WVALID = 1'b1; WDATA = 64'h5555_AAAA_5555_AAAA; WUSER = 4'b0100; WLAST = 1'b1; #1;
    n_cmp++; if ({mem_en, mem_we, mem_wstrb} !== {2'b11, 8'h0F}) begin n_err++; $display("FAIL stall_wr: got en=%b we=%b strb=%h want 1 1 0f", mem_en, mem_we, mem_wstrb); end
    @(negedge ACLK); WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1; #1;
    n_cmp++; if ({mem_en, mem_we} !== 2'b10) begin n_err++; $display("FAIL stall_retry: got en,we=%b want 10", {mem_en, mem_we}); end
    @(negedge ACLK); BREADY = 1'b0; #1;
    n_cmp++; if (RVALID !== 1'b0) begin n_err++; $display("FAIL stall_early: got rvalid=%b want 0", RVALID); end
    @(negedge ACLK); #1;
    n_cmp++; if ({RVALID, RDATA} !== {1'b1, 64'hCAFE_F00D_5555_AAAA}) begin n_err++; $display("FAIL stall_data: got rvalid=%b data=%h want 1 cafef00d5555aaaa", RVALID, RDATA); end
    @(negedge ACLK); RREADY = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge ACLK); ARVALID = 1'b1; ARADDR = 32'h8000_0008; AWVALID = 1'b1; AWADDR = 32'h9000_0008;
    @(negedge ACLK); ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b1; WDATA = 64'h1; WUSER = 4'b1000; WLAST = 1'b1;
    @(negedge ACLK); WVALID = 1'b0; WLAST = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      @(negedge ACLK); #1;
      n_cmp++; if ({RVALID, ARREADY, RRESP, RDATA} !== {2'b10, 2'b00, 64'h0102_0304_0506_0708}) begin
        n_err++; $display("FAIL hold_r cyc%0d: got rvalid=%b arready=%b rresp=%b rdata=%h want 1 0 00 0102030405060708", c, RVALID, ARREADY, RRESP, RDATA);
      end
      n_cmp++; if ({BVALID, AWREADY, BRESP} !== 4'b1011) begin
        n_err++; $display("FAIL hold_b cyc%0d: got bvalid=%b awready=%b bresp=%b want 1 0 11", c, BVALID, AWREADY, BRESP);
      end
    end
    @(negedge ACLK); RREADY = 1'b1; BREADY = 1'b1;
    @(negedge ACLK); RREADY = 1'b0; BREADY = 1'b0; #1;
    n_cmp++; if ({RVALID, BVALID, ARREADY, AWREADY} !== 4'b0011) begin n_err++; $display("FAIL hold_release: got rv,bv,arr,awr=%b want 0011", {RVALID, BVALID, ARREADY, AWREADY}); end
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK); AWVALID = 1'b1; AWADDR = 32'h8000_0038;
    @(negedge ACLK); AWVALID = 1'b0; WVALID = 1'b1; WDATA = 64'h77; WUSER = 4'b1000; WLAST = 1'b1;
    ARVALID = 1'b1; ARADDR = 32'h8000_0008;
    @(negedge ACLK); WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
    @(negedge ACLK); ARESET = 1'b1; #1;
    n_cmp++; if (BVALID !== 1'b1) begin n_err++; $display("FAIL mid_pre_bvalid: got %b want 1", BVALID); end
    @(negedge ACLK); ARESET = 1'b0; #1;
    n_cmp++; if ({RVALID, BVALID, ARREADY, AWREADY, mem_en} !== 5'b00110) begin
      n_err++; $display("FAIL mid_reset: got rv,bv,arr,awr,en=%b want 00110", {RVALID, BVALID, ARREADY, AWREADY, mem_en});
    end
    @(negedge ACLK); #1;
    n_cmp++; if ({RVALID, BVALID} !== 2'b00) begin n_err++; $display("FAIL mid_discard: got rv,bv=%b want 00", {RVALID, BVALID}); end
    test_read_vec(32'h8000_0038, 64'h77, 2'b00, 3, 29'd7);
  endtask

  initial begin
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_same_word();
    test_stall();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
